// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response ports of both masters plus the memory controller command bus
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  req0_valid, req0_write, req0_ready;
  logic                  req1_valid, req1_write, req1_ready;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, req1_wdata;
  logic                  rsp0_valid, rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata, rsp1_rdata;
  logic                  memc_read_enable, memc_write_enable, memc_busy;
  logic [ADDR_WIDTH-1:0] memc_addr;
  logic [DATA_WIDTH-1:0] memc_write_data, memc_read_data;
  logic                  owner;
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  memc_read_data, memc_busy,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    output memc_read_enable, memc_write_enable, memc_addr, memc_write_data, owner
  );
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output memc_read_data, memc_busy,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    input  memc_read_enable, memc_write_enable, memc_addr, memc_write_data, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter issuing one latched command at a time to a memory controller
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                state, next_state;
  logic                  last, owner, lwrite, winner, accept;
  logic [ADDR_WIDTH-1:0] laddr;
  logic [DATA_WIDTH-1:0] lwdata, rdata0, rdata1;
  logic [CW-1:0]         lat_cnt;
  logic [1:0]            rsp_valid;
  always_comb begin
    winner = bus.req0_valid && bus.req1_valid ? !last : bus.req1_valid;
    accept = reset && state == IDLE && !bus.memc_busy && (bus.req0_valid || bus.req1_valid);
  end
  always_ff @(posedge clk)
    state <= !reset ? IDLE : next_state;
  always_comb
    next_state = state == IDLE  ? (accept ? ISSUE : IDLE) :
                 state == ISSUE ? (lwrite ? IDLE : WAIT) :
                                  (lat_cnt == '0 ? IDLE : WAIT);
  always_ff @(posedge clk) begin
    if (!reset) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      lwrite    <= 1'b0;
      laddr     <= '0;
      lwdata    <= '0;
      lat_cnt   <= '0;
      rsp_valid <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (accept) begin
        lwrite <= winner ? bus.req1_write : bus.req0_write;
        laddr  <= winner ? bus.req1_addr  : bus.req0_addr;
        lwdata <= winner ? bus.req1_wdata : bus.req0_wdata;
        owner  <= winner;
        last   <= winner;
      end
      if (state == ISSUE) lat_cnt <= CW'(RD_LATENCY - 1);
      if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      rsp_valid <= (state == WAIT && lat_cnt == '0) ? {owner, !owner} : 2'b00;
      if (state == WAIT && lat_cnt == '0 && !owner) rdata0 <= bus.memc_read_data;
      if (state == WAIT && lat_cnt == '0 && owner) rdata1 <= bus.memc_read_data;
    end
  end
  // ready is gated by reset so nothing looks acceptable while reset is held
  assign bus.req0_ready        = accept && !winner;
  assign bus.req1_ready        = accept && winner;
  assign bus.memc_write_enable = state == ISSUE && lwrite;
  assign bus.memc_read_enable  = state == ISSUE && !lwrite;
  assign bus.memc_addr         = laddr;
  assign bus.memc_write_data   = lwdata;
  assign bus.rsp0_valid        = rsp_valid[0];
  assign bus.rsp1_valid        = rsp_valid[1];
  assign bus.rsp0_rdata        = rdata0;
  assign bus.rsp1_rdata        = rdata1;
  assign bus.owner             = owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (read latency 1 and 3) on shared stimulus, checked against a transaction timeline model
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset = 1'b0, busy = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
  logic [15:0] a0 = '0, a1 = '0;
  logic [7:0]  wd0 = '0, wd1 = '0;
  logic        rdy0[2], rdy1[2], re[2], we[2], rv0[2], rv1[2], own[2];
  logic [15:0] ma[2];
  logic [7:0]  mwd_o[2], rd0[2], rd1[2];
  function automatic int lat(input int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic logic [7:0] rdf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction
  mem_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bi[2] ();
  for (genvar g = 0; g < 2; g++) begin : inst
    int cnt = 0;
    assign bi[g].req0_valid = v0;
    assign bi[g].req0_write = w0;
    assign bi[g].req0_addr  = a0;
    assign bi[g].req0_wdata = wd0;
    assign bi[g].req1_valid = v1;
    assign bi[g].req1_write = w1;
    assign bi[g].req1_addr  = a1;
    assign bi[g].req1_wdata = wd1;
    assign bi[g].memc_busy  = busy;
    // controller stub: data is valid only in the cycle before the expected sampling edge
    always @(posedge clk) cnt <= bi[g].memc_read_enable ? 1 : (cnt != 0 ? cnt + 1 : 0);
    assign bi[g].memc_read_data = (cnt == lat(g)) ? rdf(bi[g].memc_addr) : 8'hEE;
    mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(g == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(reset), .bus(bi[g].slave));
    assign rdy0[g]  = bi[g].req0_ready;
    assign rdy1[g]  = bi[g].req1_ready;
    assign re[g]    = bi[g].memc_read_enable;
    assign we[g]    = bi[g].memc_write_enable;
    assign rv0[g]   = bi[g].rsp0_valid;
    assign rv1[g]   = bi[g].rsp1_valid;
    assign own[g]   = bi[g].owner;
    assign ma[g]    = bi[g].memc_addr;
    assign mwd_o[g] = bi[g].memc_write_data;
    assign rd0[g]   = bi[g].rsp0_rdata;
    assign rd1[g]   = bi[g].rsp1_rdata;
  end
  // model: each accepted transaction is a timeline of edges counted from its accept edge
  bit          started = 0;
  bit          act[2], mwr[2], mport[2], mlast[2], ersp[2][2];
  int          age[2];
  logic [15:0] maddr[2];
  logic [7:0]  mwd[2], erd[2][2];
  function automatic bit midle(input int i);
    return !act[i] || (mwr[i] ? age[i] >= 1 : age[i] >= lat(i) + 1);
  endfunction
  function automatic logic mwin(input int i);
    return (v0 && v1) ? !mlast[i] : v1;
  endfunction
  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit acc;
      logic p;
      acc = reset && midle(i) && !busy && (v0 || v1);
      p = mwin(i);
      ersp[i][0] = 0;
      ersp[i][1] = 0;
      if (!reset) begin
        act[i] = 0; mlast[i] = 1; mport[i] = 0; maddr[i] = '0; mwd[i] = '0;
        erd[i][0] = '0; erd[i][1] = '0; age[i] = 0;
      end else if (acc) begin
        act[i] = 1; age[i] = 0; mport[i] = p; mlast[i] = p;
        mwr[i] = p ? w1 : w0; maddr[i] = p ? a1 : a0; mwd[i] = p ? wd1 : wd0;
      end else if (act[i]) begin
        age[i]++;
        if (!mwr[i] && age[i] == lat(i) + 1) begin
          ersp[i][mport[i]] = 1;
          erd[i][mport[i]] = rdf(maddr[i]);
        end
      end
    end
  end
  int checks = 0, failures = 0, cyc = 0, phase = 0;
  bit final_req = 0, final_done = 0;
  task automatic chk(input string n, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, i, cyc, got, exp);
    end
  endtask
  logic [15:0] rr_a[$];
  int          rr_c[$];
  int          n_re2 = 0, n_rsp1_2 = 0, n_rsp0_2 = 0, n_str3 = 0, n_we30 = 0, n_rsp5 = 0;
  int          b2b_hit[2] = '{0, 0};
  logic [15:0] re_addr2 = '0, addr30 = '0;
  logic [7:0]  r2_data = '0;
  always @(negedge clk) if (started) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      logic win;
      rdy = reset && midle(i) && !busy && (v0 || v1);
      win = mwin(i);
      chk("req0_ready", i, 32'(rdy0[i]), 32'(rdy && !win));
      chk("req1_ready", i, 32'(rdy1[i]), 32'(rdy && win));
      chk("read_enable", i, 32'(re[i]), 32'(act[i] && age[i] == 0 && !mwr[i]));
      chk("write_enable", i, 32'(we[i]), 32'(act[i] && age[i] == 0 && mwr[i]));
      chk("memc_addr", i, 32'(ma[i]), 32'(maddr[i]));
      chk("memc_write_data", i, 32'(mwd_o[i]), 32'(mwd[i]));
      chk("rsp0_valid", i, 32'(rv0[i]), 32'(ersp[i][0]));
      chk("rsp1_valid", i, 32'(rv1[i]), 32'(ersp[i][1]));
      chk("rsp0_rdata", i, 32'(rd0[i]), 32'(erd[i][0]));
      chk("rsp1_rdata", i, 32'(rd1[i]), 32'(erd[i][1]));
      chk("owner", i, 32'(own[i]), 32'(mport[i]));
      if (phase == 4 && rv0[i] && rdy1[i]) b2b_hit[i]++;
      if (phase == 5 && (rv0[i] || rv1[i])) n_rsp5++;
    end
    if (phase == 1 && we[0]) begin rr_a.push_back(ma[0]); rr_c.push_back(cyc); end
    if (phase == 2 && re[0]) begin n_re2++; re_addr2 = ma[0]; end
    if (phase == 2 && rv1[0]) begin n_rsp1_2++; r2_data = rd1[0]; end
    if (phase == 2 && rv0[0]) n_rsp0_2++;
    if (phase == 3 && (re[0] || we[0] || re[1] || we[1])) n_str3++;
    if (phase == 30 && we[0]) begin n_we30++; addr30 = ma[0]; end
    if (final_req && !final_done) begin
      final_done = 1;
      chk("rr_strobes>=4", 0, 32'(rr_a.size() >= 4), 1);
      for (int k = 0; k < 4 && k < rr_a.size(); k++) begin
        chk("rr_addr", 0, 32'(rr_a[k]), (k % 2) ? 32'h8000 : 32'h0000);
        if (k > 0) chk("rr_spacing", 0, 32'(rr_c[k] - rr_c[k-1]), 2);
      end
      chk("single_read_strobes", 0, 32'(n_re2), 1);
      chk("single_read_addr", 0, 32'(re_addr2), 32'h1234);
      chk("single_read_rsp1", 0, 32'(n_rsp1_2), 1);
      chk("single_read_rdata", 0, 32'(r2_data), 32'hA5);
      chk("single_read_rsp0", 0, 32'(n_rsp0_2), 0);
      chk("busy_strobes", 0, 32'(n_str3), 0);
      chk("after_busy_writes", 0, 32'(n_we30), 1);
      chk("after_busy_addr", 0, 32'(addr30), 32'h0042);
      chk("b2b_overlap", 0, 32'(b2b_hit[0] != 0), 1);
      chk("b2b_overlap", 1, 32'(b2b_hit[1] != 0), 1);
      chk("reset_mid_read_rsp", 1, 32'(n_rsp5), 0);
      chk("reset_mid_read_rdata", 1, 32'(rd0[1]), 0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    phase = 1;
    v0 = 1; v1 = 1; w0 = 1; w1 = 1; a0 = 16'h0000; a1 = 16'h8000; wd0 = 8'h11; wd1 = 8'h22;
    repeat (3) tick();
    reset = 1;
    repeat (9) tick();
    v0 = 0; v1 = 0;
    repeat (3) tick();
    phase = 2;
    v1 = 1; w1 = 0; a1 = 16'h1234;
    tick();
    v1 = 0;
    repeat (8) tick();
    phase = 3;
    busy = 1; v0 = 1; w0 = 1; a0 = 16'h0042; wd0 = 8'h5A;
    repeat (10) tick();
    phase = 30;
    busy = 0;
    tick();
    v0 = 0;
    repeat (3) tick();
    phase = 4;
    v0 = 1; w0 = 0; a0 = 16'h0010;
    tick();
    v0 = 0; v1 = 1; w1 = 1; a1 = 16'h0020; wd1 = 8'h33;
    repeat (8) tick();
    v1 = 0;
    repeat (4) tick();
    phase = 5;
    v0 = 1; w0 = 0; a0 = 16'h0077;
    tick();
    v0 = 0;
    tick();
    reset = 0;
    tick();
    reset = 1;
    repeat (6) tick();
    phase = 0;
    final_req = 1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
